vc32_bus_target: RTL

//  Memory-side responder for the vc32 8-bit multiplexed external bus driven by the CPU bus bridge.

---
 rtl/vc32_bus_pkg.sv | 20 ++
 rtl/vc32_bus_ram.sv | 29 ++
 rtl/vc32_bus_target.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vc32_bus_pkg.sv
// Shared definitions for the vc32 multiplexed external bus: strobe bit
// positions, target FSM state encoding and the default MMIO address.
package vc32_bus_pkg;

  // Bit positions inside the 4-bit strobe bundle {latch_lo, latch_hi, write, ind}
  localparam int STB_IND = 0;
  localparam int STB_WR  = 1;
  localparam int STB_HI  = 2;
  localparam int STB_LO  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_ADDR = 2'd2,
    ST_WR   = 2'd3
  } bus_state_t;

  localparam logic [15:0] DEFAULT_IRQ_ADDR = 16'hFFFE;

endpackage

// File: rtl/vc32_bus_ram.sv
// Byte RAM with one asynchronous read port and two synchronous write ports.
// Port A (the bus) wins when both ports target the same byte on one edge.
module vc32_bus_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 a_en,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [7:0]           a_data,
  input  logic                 b_en,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [7:0]           b_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [7:0]           rd_data
);

  logic [7:0] mem [2**ADDR_BITS];

  // Commit both write ports; port B steps aside on an address collision.
  // NOTE: the array has no reset branch on purpose -- contents survive reset
  // and a reset loop over every entry would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (a_en) mem[a_addr] <= a_data;
    if (b_en && !(a_en && (a_addr == b_addr))) mem[b_addr] <= b_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vc32_bus_target.sv
// Memory-side responder for the vc32 8-bit multiplexed bus. Follows the
// strobe sequence, latches hi/lo address phases, stores write bytes into
// RAM or the MMIO interrupt register, and returns read bytes combinationally.
module vc32_bus_target
  import vc32_bus_pkg::*;
#(
  parameter int          ADDR_BITS = 10,
  parameter logic [15:0] IRQ_ADDR  = DEFAULT_IRQ_ADDR
) (
  input  logic                 clk,
  input  logic                 r_reset,
  input  logic [7:0]           bus_in,
  input  logic [3:0]           strobe_in,
  output logic [7:0]           rd_data,
  output logic                 irq,
  output logic                 err,
  input  logic                 ld_en,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [7:0]           ld_data
);

  bus_state_t state;
  logic [7:0] addr_hi;
  logic [7:1] addr_lo;   // bit 0 of the lo phase is replaced by ind

  logic       s_ind, s_wr, s_hi, s_lo;
  logic [7:1] lo_sel;
  logic [15:0] ba;
  logic       ram_hit;
  logic       is_irq;
  logic       store_en;
  logic [7:0] ram_rd;

  assign s_ind = strobe_in[STB_IND];
  assign s_wr  = strobe_in[STB_WR];
  assign s_hi  = strobe_in[STB_HI];
  assign s_lo  = strobe_in[STB_LO];

  // The lo byte is live on the bus during its latch cycle so the CPU can
  // sample read data in that same cycle.
  assign lo_sel  = s_lo ? bus_in[7:1] : addr_lo;
  assign ba      = {addr_hi, lo_sel, s_ind};
  assign ram_hit = (ba[15:ADDR_BITS] == '0);
  assign is_irq  = (ba == IRQ_ADDR);

  // A clean write strobe in a data state stores one byte; errors and reset
  // suppress it.
  assign store_en = s_wr && !s_hi && !s_lo && !r_reset &&
                    ((state == ST_ADDR) || (state == ST_WR));

  vc32_bus_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk     (clk),
    .a_en    (store_en && ram_hit),
    .a_addr  (ba[ADDR_BITS-1:0]),
    .a_data  (bus_in),
    .b_en    (ld_en),
    .b_addr  (ld_addr),
    .b_data  (ld_data),
    .rd_addr (ba[ADDR_BITS-1:0]),
    .rd_data (ram_rd)
  );

  // Read decode: RAM first, then the MMIO register, otherwise zero.
  // NOTE: every branch assigns rd_data after a default, so no latch forms.
  always_comb begin
    rd_data = 8'h00;
    if (ram_hit)     rd_data = ram_rd;
    else if (is_irq) rd_data = {7'b0, irq};
  end

  // Strobe-sequence FSM with address latches, MMIO register and sticky error.
  // NOTE: all state here uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      state   <= ST_IDLE;
      addr_hi <= 8'h00;
      addr_lo <= 7'h00;
      irq     <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (store_en && !ram_hit && is_irq) irq <= bus_in[0];

      if (s_hi && s_lo) begin
        err   <= 1'b1;
        state <= ST_IDLE;
      end else if (s_wr && (s_hi || s_lo)) begin
        err   <= 1'b1;
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (s_hi) begin
              addr_hi <= bus_in;
              state   <= ST_HI;
            end else if (s_wr) begin
              err <= 1'b1;
            end
          end
          ST_HI: begin
            if (s_lo) begin
              addr_lo <= bus_in[7:1];
              state   <= ST_ADDR;
            end else if (s_hi) begin
              addr_hi <= bus_in;
            end else if (s_wr) begin
              err   <= 1'b1;
              state <= ST_IDLE;
            end
          end
          ST_ADDR: begin
            if (s_wr) begin
              state <= ST_WR;
            end else if (s_hi) begin
              addr_hi <= bus_in;
              state   <= ST_HI;
            end
          end
          ST_WR: begin
            if (s_wr) begin
              state <= ST_WR;
            end else if (s_hi) begin
              addr_hi <= bus_in;
              state   <= ST_HI;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
